// File: rtl/mips_pkg.sv
// Shared opcodes, FSM state encoding and control-field codes for the
// multi-cycle MIPS control unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_ADDIEX = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_JUMP   = 4'd13
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_base_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  function automatic logic is_ext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control word for the current FSM state (and opcode/ready
// where a strobe or done pulse depends on them).
module mc_ctrl_decode
  import mips_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  state_t     i_state,
  input  logic [5:0] i_op,
  input  logic       i_rdy,
  input  logic       i_started,
  output ctrl_t      o_ctrl
);

  logic w_legal;
  assign w_legal = is_base_op(i_op) || ((EXT_OPS != 0) && is_ext_op(i_op));

  // Per-state control word; fields not set for a state stay 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        // Fetch strobes are held off until the first clock after reset release.
        o_ctrl.mem_req = i_started;
        o_ctrl.irwrite = i_started & i_rdy;
        o_ctrl.pcwrite = i_started & i_rdy;
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop   = ALU_ADD;
        o_ctrl.pcsrc   = PC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alusrcb    = SRCB_IMMSH;
        o_ctrl.aluop      = ALU_ADD;
        o_ctrl.illegal_op = ~w_legal;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.memtoreg   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_req    = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.memwrite   = i_rdy;
        o_ctrl.instr_done = i_rdy;
      end
      S_EXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_RT;
        o_ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.regdst     = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.alusrcb    = SRCB_RT;
        o_ctrl.aluop      = ALU_SUB;
        o_ctrl.pcsrc      = PC_ALUOUT;
        o_ctrl.branch     = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BNE: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.alusrcb    = SRCB_RT;
        o_ctrl.aluop      = ALU_SUB;
        o_ctrl.pcsrc      = PC_ALUOUT;
        o_ctrl.branch_ne  = (EXT_OPS != 0);
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALU_ADD;
      end
      S_IEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        case (i_op)
          OP_ANDI: begin o_ctrl.aluop = ALU_AND; o_ctrl.zeroext = 1'b1; end
          OP_ORI:  begin o_ctrl.aluop = ALU_OR;  o_ctrl.zeroext = 1'b1; end
          default: o_ctrl.aluop = ALU_SLT;
        endcase
      end
      S_IWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pcsrc      = PC_JUMP;
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: state sequencing and retired-instruction
// counter; the control word itself comes from mc_ctrl_decode.
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int unsigned EXT_OPS  = 1,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [2:0]       aluop,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             regdst,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  logic             r_started;
  logic [CNT_W-1:0] r_retired;
  logic             w_rdy;
  ctrl_t            w_ctrl;

  assign w_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  mc_ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .i_state   (r_state),
    .i_op      (op),
    .i_rdy     (w_rdy),
    .i_started (r_started),
    .o_ctrl    (w_ctrl)
  );

  // State sequencing, first-clock tracking and retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_started <= 1'b0;
      r_retired <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_ctrl.instr_done) r_retired <= r_retired + 1'b1;
      case (r_state)
        // Fetch only completes once the gated fetch strobes were actually issued.
        S_FETCH:  if (r_started && w_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BEQ;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            OP_ANDI, OP_ORI, OP_SLTI:
                          r_state <= (EXT_OPS != 0) ? S_IEXEC : S_FETCH;
            OP_BNE:       r_state <= (EXT_OPS != 0) ? S_BNE : S_FETCH;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (w_rdy) r_state <= S_MEMWB;
        S_MEMWR:  if (w_rdy) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_IWB;
        S_IEXEC:  r_state <= S_IWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign mem_req    = w_ctrl.mem_req;
  assign iord       = w_ctrl.iord;
  assign irwrite    = w_ctrl.irwrite;
  assign pcwrite    = w_ctrl.pcwrite;
  assign branch     = w_ctrl.branch;
  assign branch_ne  = w_ctrl.branch_ne;
  assign pcsrc      = w_ctrl.pcsrc;
  assign alusrca    = w_ctrl.alusrca;
  assign alusrcb    = w_ctrl.alusrcb;
  assign zeroext    = w_ctrl.zeroext;
  assign aluop      = w_ctrl.aluop;
  assign memwrite   = w_ctrl.memwrite;
  assign memtoreg   = w_ctrl.memtoreg;
  assign regwrite   = w_ctrl.regwrite;
  assign regdst     = w_ctrl.regdst;
  assign instr_done = w_ctrl.instr_done;
  assign illegal_op = w_ctrl.illegal_op;
  assign retired    = r_retired;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a default instance (EXT_OPS=1, CNT_W=32)
// and an alternate instance (EXT_OPS=0, CNT_W=4) share clock and stimulus.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;

  // Output word layout:
  // mem_req iord irwrite pcwrite branch branch_ne pcsrc[2] alusrca alusrcb[2]
  // zeroext aluop[3] memwrite memtoreg regwrite regdst instr_done illegal_op
  localparam logic [20:0] E_FRST = 21'b0_0_0_0_0_0_00_0_01_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_FWT  = 21'b1_0_0_0_0_0_00_0_01_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_FRDY = 21'b1_0_1_1_0_0_00_0_01_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_DEC  = 21'b0_0_0_0_0_0_00_0_11_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_DILL = 21'b0_0_0_0_0_0_00_0_11_0_000_0_0_0_0_0_1;
  localparam logic [20:0] E_MADR = 21'b0_0_0_0_0_0_00_1_10_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_MRD  = 21'b1_1_0_0_0_0_00_0_00_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_MWB  = 21'b0_0_0_0_0_0_00_0_00_0_000_0_1_1_0_1_0;
  localparam logic [20:0] E_MWWT = 21'b1_1_0_0_0_0_00_0_00_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_MWR  = 21'b1_1_0_0_0_0_00_0_00_0_000_1_0_0_0_1_0;
  localparam logic [20:0] E_EXEC = 21'b0_0_0_0_0_0_00_1_00_0_010_0_0_0_0_0_0;
  localparam logic [20:0] E_AWB  = 21'b0_0_0_0_0_0_00_0_00_0_000_0_0_1_1_1_0;
  localparam logic [20:0] E_BEQ  = 21'b0_0_0_0_1_0_01_1_00_0_001_0_0_0_0_1_0;
  localparam logic [20:0] E_BNE  = 21'b0_0_0_0_0_1_01_1_00_0_001_0_0_0_0_1_0;
  localparam logic [20:0] E_ADDI = 21'b0_0_0_0_0_0_00_1_10_0_000_0_0_0_0_0_0;
  localparam logic [20:0] E_ORI  = 21'b0_0_0_0_0_0_00_1_10_1_100_0_0_0_0_0_0;
  localparam logic [20:0] E_IWB  = 21'b0_0_0_0_0_0_00_0_00_0_000_0_0_1_0_1_0;
  localparam logic [20:0] E_JMP  = 21'b0_0_0_1_0_0_10_0_00_0_000_0_0_0_0_1_0;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000,
                         T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000,
                         T_ORI = 6'b001101, T_BNE = 6'b000101, T_BAD = 6'b111111;

  // Default instance
  logic        mem_req, iord, irwrite, pcwrite, branch, branch_ne, alusrca, zeroext;
  logic        memwrite, memtoreg, regwrite, regdst, instr_done, illegal_op;
  logic [1:0]  pcsrc, alusrcb;
  logic [2:0]  aluop;
  logic [31:0] retired;
  logic [20:0] w_sig;

  // Alternate instance
  logic        a_mem_req, a_iord, a_irwrite, a_pcwrite, a_branch, a_branch_ne, a_alusrca, a_zeroext;
  logic        a_memwrite, a_memtoreg, a_regwrite, a_regdst, a_instr_done, a_illegal_op;
  logic [1:0]  a_pcsrc, a_alusrcb;
  logic [2:0]  a_aluop;
  logic [3:0]  a_retired;
  logic [20:0] w_sig_a;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  assign w_sig = {mem_req, iord, irwrite, pcwrite, branch, branch_ne, pcsrc, alusrca,
                  alusrcb, zeroext, aluop, memwrite, memtoreg, regwrite, regdst,
                  instr_done, illegal_op};
  assign w_sig_a = {a_mem_req, a_iord, a_irwrite, a_pcwrite, a_branch, a_branch_ne, a_pcsrc,
                    a_alusrca, a_alusrcb, a_zeroext, a_aluop, a_memwrite, a_memtoreg,
                    a_regwrite, a_regdst, a_instr_done, a_illegal_op};

  mc_control_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .branch_ne(branch_ne), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop), .memwrite(memwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .regdst(regdst),
    .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
  );

  mc_control_fsm #(.EXT_OPS(0), .MEM_WAIT(1), .CNT_W(4)) u_alt (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .iord(a_iord), .irwrite(a_irwrite), .pcwrite(a_pcwrite),
    .branch(a_branch), .branch_ne(a_branch_ne), .pcsrc(a_pcsrc), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .zeroext(a_zeroext), .aluop(a_aluop), .memwrite(a_memwrite),
    .memtoreg(a_memtoreg), .regwrite(a_regwrite), .regdst(a_regdst),
    .instr_done(a_instr_done), .illegal_op(a_illegal_op), .retired(a_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check the default instance
  // (and optionally the alternate), then advance to just after the next edge.
  task automatic cyc(input logic [5:0] o, input logic r, input logic [20:0] e,
                     input string tag, input logic use_a = 1'b0,
                     input logic [20:0] ea = '0);
    op = o;
    mem_ready = r;
    #1;
    chk(tag, {11'd0, w_sig}, {11'd0, e});
    if (use_a) chk({tag, "_alt"}, {11'd0, w_sig_a}, {11'd0, ea});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_sig", {11'd0, w_sig}, {11'd0, E_FRST});
    chk("rst_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_release_gate", {11'd0, w_sig}, {11'd0, E_FRST});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    op = T_LW;
    mem_ready = 1'b1;
    #12;
    do_reset();

    // lw, 5 cycles
    cyc(T_LW, 1, E_FRDY, "lw_fetch");
    cyc(T_LW, 1, E_DEC,  "lw_decode");
    cyc(T_LW, 1, E_MADR, "lw_memadr");
    cyc(T_LW, 1, E_MRD,  "lw_memrd");
    chk("lw_retired_before", retired, 32'd0);
    cyc(T_LW, 1, E_MWB,  "lw_memwb");
    chk("lw_retired_after", retired, 32'd1);

    // sw with three wait cycles in MEMWR, 7 cycles
    cyc(T_SW, 1, E_FRDY, "sw_fetch");
    cyc(T_SW, 1, E_DEC,  "sw_decode");
    cyc(T_SW, 1, E_MADR, "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(T_SW, 0, E_MWWT, "sw_wait");
    cyc(T_SW, 1, E_MWR,  "sw_write");
    chk("sw_retired", retired, 32'd2);

    // R-type, beq, j
    cyc(T_R,   1, E_FRDY, "r_fetch");
    cyc(T_R,   1, E_DEC,  "r_decode");
    cyc(T_R,   1, E_EXEC, "r_exec");
    cyc(T_R,   1, E_AWB,  "r_aluwb");
    cyc(T_BEQ, 1, E_FRDY, "beq_fetch");
    cyc(T_BEQ, 1, E_DEC,  "beq_decode");
    cyc(T_BEQ, 1, E_BEQ,  "beq_exec");
    cyc(T_J,   1, E_FRDY, "j_fetch");
    cyc(T_J,   1, E_DEC,  "j_decode");
    cyc(T_J,   1, E_JMP,  "j_jump");
    chk("rbj_retired", retired, 32'd5);

    // Illegal opcode with one fetch wait cycle; not counted
    cyc(T_BAD, 0, E_FWT,  "ill_fetch_wait");
    cyc(T_BAD, 1, E_FRDY, "ill_fetch");
    cyc(T_BAD, 1, E_DILL, "ill_decode");
    chk("ill_retired", retired, 32'd5);

    // Reset asserted while lw holds in MEMRD
    cyc(T_LW, 1, E_FRDY, "abort_fetch");
    cyc(T_LW, 1, E_DEC,  "abort_decode");
    cyc(T_LW, 1, E_MADR, "abort_memadr");
    cyc(T_LW, 0, E_MRD,  "abort_memrd_hold");
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_sig", {11'd0, w_sig}, {11'd0, E_FRST});
    chk("abort_retired", retired, 32'd0);
    do_reset();

    // ori: legal on the default instance, illegal on the alternate
    cyc(T_ORI, 1, E_FRDY, "ori_fetch",  1'b1, E_FRDY);
    cyc(T_ORI, 1, E_DEC,  "ori_decode", 1'b1, E_DILL);
    cyc(T_ORI, 1, E_ORI,  "ori_iexec", 1'b1, E_FRDY);
    cyc(T_ORI, 1, E_IWB,  "ori_iwb");
    chk("ori_retired", retired, 32'd1);
    chk("ori_alt_retired", {28'd0, a_retired}, 32'd0);

    // bne on the default instance
    cyc(T_BNE, 1, E_FRDY, "bne_fetch");
    cyc(T_BNE, 1, E_DEC,  "bne_decode");
    cyc(T_BNE, 1, E_BNE,  "bne_exec");
    chk("bne_retired", retired, 32'd2);

    // 16 addi: 4-bit counter on the alternate wraps 15 -> 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(T_ADDI, 1, E_FRDY, "addi_fetch");
      cyc(T_ADDI, 1, E_DEC,  "addi_decode");
      cyc(T_ADDI, 1, E_ADDI, "addi_exec");
      cyc(T_ADDI, 1, E_IWB,  "addi_iwb");
      if (i == 14) chk("wrap_alt_15", {28'd0, a_retired}, 32'd15);
    end
    chk("wrap_alt_0", {28'd0, a_retired}, 32'd0);
    chk("wrap_main_16", retired, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
